// File: rtl/clk_div_monitor_if.sv
// Interface bundling the monitor's enable, divided input, expected period and measurement results.
// duty_err exists only when CLK_DIV_MON_DUTY_EN is defined.
interface clk_div_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             div_in;
  logic [CNT_W-1:0] exp_period;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_vld;
  logic             locked;
  logic             mismatch;
  logic             timeout;
`ifdef CLK_DIV_MON_DUTY_EN
  logic             duty_err;
`endif

  modport master (
    output en, div_in, exp_period,
    input  period, high_time, period_vld, locked, mismatch, timeout
`ifdef CLK_DIV_MON_DUTY_EN
    , input duty_err
`endif
  );

  modport slave (
    input  en, div_in, exp_period,
    output period, high_time, period_vld, locked, mismatch, timeout
`ifdef CLK_DIV_MON_DUTY_EN
    , output duty_err
`endif
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures period/high time of div_in in clk cycles, tracks lock, flags mismatch and timeout.
// Optional duty-cycle check enabled by defining CLK_DIV_MON_DUTY_EN.
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input logic              clk,
  input logic              reset,
  clk_div_monitor_if.slave mon
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FIRST   = 3'd1;
  localparam logic [2:0] MEASURE = 3'd2;
  localparam logic [2:0] TRACK   = 3'd3;
  localparam logic [2:0] LOCKED  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [3:0]       LOCK_N  = LOCK_CNT[3:0];

  logic             div_d;
  logic             rise;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] pcnt_nxt;
  logic [CNT_W-1:0] hcnt_nxt;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [3:0]       match_cnt;
  logic [3:0]       match_nxt;
  logic [3:0]       match_inc;
  logic             capture;
  logic             same_period;
  logic             duty_bad;
  logic             locked_nxt;
  logic             mismatch_nxt;
  logic             timeout_nxt;

  assign rise        = mon.div_in & ~div_d;
  assign same_period = (pcnt == mon.period);
  assign match_inc   = match_cnt + 4'd1;

`ifdef CLK_DIV_MON_DUTY_EN
  // Even periods need exactly half high; odd periods allow the high time to be off by one half-cycle.
  function automatic logic duty_check(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] h);
    logic [CNT_W+1:0] h2;
    logic [CNT_W+1:0] pp;
    h2 = {1'b0, h, 1'b0};
    pp = {2'b00, p};
    if (p[0] == 1'b0) begin
      duty_check = (h2 != pp);
    end else begin
      duty_check = (h2 != pp + {{(CNT_W+1){1'b0}}, 1'b1}) && (pp != h2 + {{(CNT_W+1){1'b0}}, 1'b1});
    end
  endfunction

  assign duty_bad = duty_check(pcnt, hcnt);
`else
  assign duty_bad = 1'b0;
`endif

  // Period and high-time counters, cleared while idle or disabled, saturating otherwise.
  always_comb begin
    pcnt_nxt = pcnt;
    hcnt_nxt = hcnt;
    if (!mon.en || state == IDLE) begin
      pcnt_nxt = CNT_ZERO;
      hcnt_nxt = CNT_ZERO;
    end else if (rise) begin
      pcnt_nxt = CNT_ONE;
      hcnt_nxt = CNT_ONE;
    end else begin
      pcnt_nxt = (pcnt == CNT_MAX) ? pcnt : pcnt + CNT_ONE;
      if (mon.div_in && hcnt != CNT_MAX) begin
        hcnt_nxt = hcnt + CNT_ONE;
      end else begin
        hcnt_nxt = hcnt;
      end
    end
  end

  // Lock state machine; en low overrides any rise in the same cycle.
  always_comb begin
    state_nxt   = state;
    match_nxt   = match_cnt;
    locked_nxt  = mon.locked;
    capture     = 1'b0;
    timeout_nxt = 1'b0;
    if (!mon.en) begin
      state_nxt  = IDLE;
      match_nxt  = 4'd0;
      locked_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt  = FIRST;
          locked_nxt = 1'b0;
        end
        FIRST: begin
          if (rise) begin
            state_nxt = MEASURE;
          end else begin
            state_nxt = FIRST;
          end
        end
        MEASURE, TRACK, LOCKED: begin
          if (rise) begin
            capture = 1'b1;
            if (state == MEASURE) begin
              match_nxt = 4'd1;
              state_nxt = TRACK;
            end else if (state == TRACK) begin
              if (same_period) begin
                match_nxt = match_inc;
                if (match_inc >= LOCK_N) begin
                  state_nxt  = LOCKED;
                  locked_nxt = 1'b1;
                end else begin
                  state_nxt = TRACK;
                end
              end else begin
                match_nxt = 4'd1;
              end
            end else if (!same_period || duty_bad) begin
              match_nxt  = 4'd1;
              locked_nxt = 1'b0;
              state_nxt  = TRACK;
            end else begin
              state_nxt = LOCKED;
            end
          end else if (pcnt == CNT_MAX) begin
            timeout_nxt = 1'b1;
            locked_nxt  = 1'b0;
            state_nxt   = FIRST;
          end else begin
            state_nxt = state;
          end
        end
        default: begin
          state_nxt  = IDLE;
          match_nxt  = 4'd0;
          locked_nxt = 1'b0;
        end
      endcase
    end
    mismatch_nxt = capture && (mon.exp_period != CNT_ZERO) && (pcnt != mon.exp_period);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_d          <= 1'b0;
      state          <= IDLE;
      pcnt           <= CNT_ZERO;
      hcnt           <= CNT_ZERO;
      match_cnt      <= 4'd0;
      mon.period     <= CNT_ZERO;
      mon.high_time  <= CNT_ZERO;
      mon.period_vld <= 1'b0;
      mon.locked     <= 1'b0;
      mon.mismatch   <= 1'b0;
      mon.timeout    <= 1'b0;
`ifdef CLK_DIV_MON_DUTY_EN
      mon.duty_err   <= 1'b0;
`endif
    end else begin
      div_d          <= mon.div_in;
      state          <= state_nxt;
      pcnt           <= pcnt_nxt;
      hcnt           <= hcnt_nxt;
      match_cnt      <= match_nxt;
      mon.locked     <= locked_nxt;
      mon.period_vld <= capture;
      mon.mismatch   <= mismatch_nxt;
      mon.timeout    <= timeout_nxt;
`ifdef CLK_DIV_MON_DUTY_EN
      mon.duty_err   <= capture && duty_bad;
`endif
      if (capture) begin
        mon.period    <= pcnt;
        mon.high_time <= hcnt;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor: vector table of divider shapes plus lock, switch, timeout, reset and duty sequences.
module tb_clk_div_monitor;

  typedef struct {
    int         h;
    int         l;
    int         n;
    logic [7:0] expp;
    logic [7:0] ep;
    logic [7:0] eh;
    logic       el;
  } vec_t;

  typedef struct {
    logic [7:0] p;
    logic [7:0] h;
    logic       mis;
    logic       duty;
  } exp_t;

`ifdef CLK_DIV_MON_DUTY_EN
  localparam logic DUTY_LOCK = 1'b0;
`else
  localparam logic DUTY_LOCK = 1'b1;
`endif

  logic clk;
  logic reset;
  clk_div_monitor_if #(.CNT_W(8)) mon ();

  clk_div_monitor #(.CNT_W(8), .LOCK_CNT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mon.slave)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         to_cnt = 0;
  int         to_base;
  exp_t       exp_q[$];
  logic       meas_active = 1'b0;
  logic [7:0] prev_p = 8'd0;
  logic [7:0] prev_h = 8'd0;
  vec_t       vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic duty_model(input int p, input int h);
    if (p % 2 == 0) return (2 * h != p);
    else return (2 * h != p + 1) && (2 * h + 1 != p);
  endfunction

  // Scoreboard: every period_vld must match the oldest expected record.
  always @(negedge clk) begin
    exp_t e;
    if (mon.timeout) to_cnt++;
    if (mon.mismatch && !mon.period_vld) begin
      n_cmp++;
      n_err++;
      $display("FAIL mismatch_without_vld: got 1, required 0");
    end
    if (mon.period_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_vld: period %0d, required no pulse", mon.period);
      end else begin
        e = exp_q.pop_front();
        chk("period", 32'(mon.period), 32'(e.p));
        chk("high_time", 32'(mon.high_time), 32'(e.h));
        chk("mismatch", 32'(mon.mismatch), 32'(e.mis));
`ifdef CLK_DIV_MON_DUTY_EN
        chk("duty_err", 32'(mon.duty_err), 32'(e.duty));
`endif
      end
    end
  end

  task automatic cyc(input logic v);
    mon.div_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic rise_only();
    exp_t e;
    if (meas_active) begin
      e.p    = prev_p;
      e.h    = prev_h;
      e.mis  = (mon.exp_period != 8'd0) && (prev_p != mon.exp_period);
      e.duty = duty_model(int'(prev_p), int'(prev_h));
      exp_q.push_back(e);
    end
    meas_active = 1'b1;
  endtask

  task automatic run_wave(input int h, input int l, input int n, input logic [7:0] ep, input logic [7:0] eh);
    for (int k = 0; k < n; k++) begin
      rise_only();
      for (int j = 0; j < h; j++) cyc(1'b1);
      for (int j = 0; j < l; j++) cyc(1'b0);
      prev_p = ep;
      prev_h = eh;
    end
  endtask

  task automatic fresh_start();
    mon.en = 1'b0;
    meas_active = 1'b0;
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b1);
    chk("en_low_locked", 32'(mon.locked), 32'd0);
    mon.en = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
  endtask

  initial begin
    vecs[0] = '{1, 1, 6, 8'd0, 8'd2, 8'd1, 1'b1};
    vecs[1] = '{2, 2, 6, 8'd0, 8'd4, 8'd2, 1'b1};
    vecs[2] = '{4, 4, 6, 8'd0, 8'd8, 8'd4, 1'b1};
    vecs[3] = '{2, 2, 6, 8'd8, 8'd4, 8'd2, 1'b1};
    vecs[4] = '{2, 1, 6, 8'd3, 8'd3, 8'd2, 1'b1};
    vecs[5] = '{1, 2, 6, 8'd5, 8'd3, 8'd1, 1'b1};

    reset = 1'b1;
    mon.en = 1'b0;
    mon.div_in = 1'b0;
    mon.exp_period = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_period", 32'(mon.period), 32'd0);
    chk("rst_high_time", 32'(mon.high_time), 32'd0);
    chk("rst_locked", 32'(mon.locked), 32'd0);
    chk("rst_vld", 32'(mon.period_vld), 32'd0);
    chk("rst_timeout", 32'(mon.timeout), 32'd0);
    reset = 1'b0;
    cyc(1'b0);

    for (int i = 0; i < 6; i++) begin
      fresh_start();
      mon.exp_period = vecs[i].expp;
      run_wave(vecs[i].h, vecs[i].l, vecs[i].n, vecs[i].ep, vecs[i].eh);
      rise_only();
      cyc(1'b1);
      chk("vec_locked", 32'(mon.locked), 32'(vecs[i].el));
    end

    // Lock timing on div4, then switch through a period-3 glitch to div2.
    fresh_start();
    mon.exp_period = 8'd0;
    run_wave(2, 2, 4, 8'd4, 8'd2);
    chk("lock_before_5th", 32'(mon.locked), 32'd0);
    rise_only();
    cyc(1'b1);
    chk("lock_after_5th", 32'(mon.locked), 32'd1);
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    prev_p = 8'd4;
    prev_h = 8'd2;
    run_wave(2, 1, 1, 8'd3, 8'd2);
    chk("still_locked_pre_switch", 32'(mon.locked), 32'd1);
    run_wave(1, 1, 1, 8'd2, 8'd1);
    chk("unlock_on_switch", 32'(mon.locked), 32'd0);
    run_wave(1, 1, 4, 8'd2, 8'd1);
    chk("relock_div2", 32'(mon.locked), 32'd1);

    // Timeout from lock on div8, then relock.
    fresh_start();
    run_wave(4, 4, 5, 8'd8, 8'd4);
    chk("div8_locked", 32'(mon.locked), 32'd1);
    to_base = to_cnt;
    repeat (300) cyc(1'b0);
    chk("timeout_pulses", 32'(to_cnt - to_base), 32'd1);
    chk("timeout_unlock", 32'(mon.locked), 32'd0);
    meas_active = 1'b0;
    run_wave(4, 4, 5, 8'd8, 8'd4);
    chk("relock_after_timeout", 32'(mon.locked), 32'd1);

    // Asynchronous reset mid-period while locked.
    cyc(1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_period", 32'(mon.period), 32'd0);
    chk("async_rst_high", 32'(mon.high_time), 32'd0);
    chk("async_rst_locked", 32'(mon.locked), 32'd0);
    exp_q.delete();
    meas_active = 1'b0;
    mon.div_in = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0);

    // Duty-cycle excursion at constant period.
    fresh_start();
    run_wave(4, 4, 5, 8'd8, 8'd4);
    chk("duty_pre_lock", 32'(mon.locked), 32'd1);
    run_wave(3, 5, 1, 8'd8, 8'd3);
    run_wave(4, 4, 1, 8'd8, 8'd4);
    chk("duty_lock", 32'(mon.locked), 32'(DUTY_LOCK));

    mon.en = 1'b0;
    repeat (4) cyc(1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("total_timeouts", 32'(to_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
